aq_axi_memcpy32_rd: RTL
=======================

Name: aq_axi_memcpy32_rd

Overview:
- AXI4 read master for the 32-bit memcpy engine.
- Sits directly downstream of the memcpy controller's read command outputs (RD_START/RD_ADRS/RD_COUNT/RD_READY).
- Fetches RD_COUNT bytes from RD_ADRS as one or more INCR bursts and pushes each returned word into the copy FIFO that feeds the write master.
- One burst outstanding at a time; FIFO full back-pressures the R channel.

Parameters:
MAX_BURST, 16, maximum beats per AR burst (1..256).

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- RD_START  in  1  one-cycle command pulse; honoured only in S_IDLE
- RD_ADRS  in  32  source byte address; bits [1:0] ignored (forced 0)
- RD_COUNT  in  32  transfer length in bytes
- RD_READY  out  1  high when idle and able to accept RD_START
- RD_ERR  out  1  sticky error flag (RRESP!=OKAY or RLAST mismatch); cleared by accepted RD_START
- M_ARADDR  out  32  burst start address
- M_ARLEN  out  8  beats-1
- M_ARSIZE  out  3  constant 3'b010
- M_ARBURST  out  2  constant 2'b01 (INCR)
- M_ARVALID  out  1  address valid
- M_ARREADY  in  1  address ready
- M_RDATA  in  32  read data
- M_RRESP  in  2  read response
- M_RLAST  in  1  last beat
- M_RVALID  in  1  data valid
- M_RREADY  out  1  data ready
- FIFO_WE  out  1  write strobe to copy FIFO
- FIFO_DATA  out  32  FIFO write data (= M_RDATA, combinational)
- FIFO_FULL  in  1  FIFO cannot accept a word this cycle

Behaviour:
- Reset values: M_ARVALID=0, M_RREADY=0, FIFO_WE=0, M_ARADDR=0, M_ARLEN=0, RD_ERR=0, state=S_IDLE, so RD_READY=1.
- States:
  - S_IDLE:
    - RD_READY=1.
    - On RD_START: latch addr=RD_ADRS&~3 and rem_beats=(RD_COUNT+3)>>2 (33-bit add, no overflow; 0xFFFFFFFF -> 0x40000000 beats); clear RD_ERR; go to S_CALC.
  - S_CALC (1 cycle):
    - If rem_beats==0, go to S_IDLE.
    - Else len=min(rem_beats, MAX_BURST, (4096-addr[11:0])>>2). The 4 KB boundary is never crossed.
    - Register M_ARADDR=addr and M_ARLEN=len-1; set M_ARVALID; go to S_AR.
  - S_AR:
    - Hold M_ARVALID and address/len stable until M_ARREADY.
    - On handshake: drop ARVALID, addr+=len*4, rem_beats-=len, beat_cnt=0; go to S_R.
  - S_R:
    - M_RREADY = !FIFO_FULL (combinational).
    - Each M_RVALID&&M_RREADY: FIFO_WE=1 and beat_cnt++.
    - Burst ends on the beat where beat_cnt==len-1; go to S_CALC.
    - If RLAST is not asserted exactly on that beat, set RD_ERR; termination is still by count.
    - Any accepted beat with RRESP!=2'b00 sets RD_ERR. The data is still written to the FIFO.
- Latency: RD_START in cycle 0 -> S_CALC in cycle 1 -> M_ARVALID in cycle 2.
- RD_READY returns one cycle after the final S_CALC.
- RD_COUNT==0: RD_START -> S_CALC -> S_IDLE, with no AXI traffic; RD_READY is low for exactly 2 cycles.
- RD_START outside S_IDLE is ignored.
- RD_ADRS, RD_COUNT, MAX_BURST: RD_ADRS and RD_COUNT are sampled only in the RD_START cycle. Non-multiple-of-4 counts round up to whole words.
- FIFO_FULL and M_RVALID high in the same cycle: the beat is not accepted and FIFO_WE=0.
- Reset mid-operation: immediate return to reset values. An in-flight AXI transaction is abandoned; the system resets the interconnect together with this block.

Test Plan:
- RD_ADRS=0x1000, RD_COUNT=64, ARREADY and RVALID always high -> one AR (ARADDR=0x1000, ARLEN=15); 16 FIFO_WE words in order; RD_READY high again; RD_ERR=0.
- RD_ADRS=0x0FF8, RD_COUNT=32 -> two bursts: 0x0FF8 with ARLEN=1, then 0x1000 with ARLEN=5; 8 words total.
- RD_ADRS=0x2000, RD_COUNT=70 -> 18 beats: ARLEN=15 at 0x2000, then ARLEN=1 at 0x2040.
- RD_COUNT=0 -> no ARVALID; RD_READY low for 2 cycles.
- FIFO_FULL toggled every other cycle during a 16-beat burst:
  - RREADY tracks !FIFO_FULL.
  - No beat is lost or duplicated.
  - FIFO_WE never asserts while FIFO_FULL=1.
- Error and reset cases:
  - Beat 3 returns RRESP=2'b10, and RLAST is asserted on beat 14 of a 16-beat burst -> RD_ERR=1 until the next RD_START; 16 beats still consumed.
  - RST_N pulsed low while in S_R -> all outputs at reset values; RD_READY=1.

Source files
------------

// File: rtl/aq_axi_memcpy32_rd.sv
// AXI4 INCR read master for the 32-bit memcpy engine: splits a byte-count request into 4 KB-safe bursts.
// RD_START to M_ARVALID takes 2 cycles; one burst in flight; FIFO_FULL stalls the R channel via M_RREADY.
module aq_axi_memcpy32_rd #(
  parameter int MAX_BURST = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RD_START,
  input  logic [31:0] RD_ADRS,
  input  logic [31:0] RD_COUNT,
  output logic        RD_READY,
  output logic        RD_ERR,
  output logic [31:0] M_ARADDR,
  output logic [7:0]  M_ARLEN,
  output logic [2:0]  M_ARSIZE,
  output logic [1:0]  M_ARBURST,
  output logic        M_ARVALID,
  input  logic        M_ARREADY,
  input  logic [31:0] M_RDATA,
  input  logic [1:0]  M_RRESP,
  input  logic        M_RLAST,
  input  logic        M_RVALID,
  output logic        M_RREADY,
  output logic        FIFO_WE,
  output logic [31:0] FIFO_DATA,
  input  logic        FIFO_FULL
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_AR   = 2'd2,
    S_R    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_addr;
  logic [30:0] r_rem;
  logic [8:0]  r_len;
  logic [8:0]  r_beat_cnt;
  logic        r_idle_q;
  logic        r_err;
  logic [31:0] r_araddr;
  logic [7:0]  r_arlen;
  logic        r_arvalid;

  logic        w_accept;
  logic        w_rready;
  logic        w_beat;
  logic        w_last;
  logic [12:0] w_4k_bytes;
  logic [10:0] w_4k_beats;
  logic [8:0]  w_cap;
  logic [8:0]  w_len;

  // RD_READY also waits one cycle of settled idle, so a zero-length command
  // keeps it low for two cycles and a finished copy re-arms one cycle later.
  assign w_accept = (r_state == S_IDLE) && r_idle_q && RD_START;

  assign w_rready = (r_state == S_R) && !FIFO_FULL;
  assign w_beat   = M_RVALID && w_rready;
  assign w_last   = (r_beat_cnt == (r_len - 9'd1));

  // Beats left before the next 4 KB page; 1..1024
  assign w_4k_bytes = 13'h1000 - {1'b0, r_addr[11:0]};
  assign w_4k_beats = w_4k_bytes[12:2];
  assign w_cap      = (w_4k_beats < 11'(MAX_BURST)) ? 9'(w_4k_beats) : 9'(MAX_BURST);
  assign w_len      = (r_rem < 31'(w_cap)) ? 9'(r_rem) : w_cap;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_CALC;
      S_CALC: w_state_nxt = (r_rem == 31'd0) ? S_IDLE : S_AR;
      S_AR:   if (M_ARREADY) w_state_nxt = S_R;
      S_R:    if (w_beat && w_last) w_state_nxt = S_CALC;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_addr     <= 32'd0;
      r_rem      <= 31'd0;
      r_len      <= 9'd0;
      r_beat_cnt <= 9'd0;
      r_idle_q   <= 1'b1;
      r_err      <= 1'b0;
      r_araddr   <= 32'd0;
      r_arlen    <= 8'd0;
      r_arvalid  <= 1'b0;
    end else begin
      r_idle_q <= (r_state == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= RD_ADRS & ~32'd3;
            r_rem  <= 31'(({1'b0, RD_COUNT} + 33'd3) >> 2);
            r_err  <= 1'b0;
          end
        end
        S_CALC: begin
          if (r_rem != 31'd0) begin
            r_len     <= w_len;
            r_araddr  <= r_addr;
            r_arlen   <= 8'(w_len - 9'd1);
            r_arvalid <= 1'b1;
          end
        end
        S_AR: begin
          if (M_ARREADY) begin
            r_arvalid  <= 1'b0;
            r_addr     <= r_addr + {21'd0, r_len, 2'b00};
            r_rem      <= r_rem - {22'd0, r_len};
            r_beat_cnt <= 9'd0;
          end
        end
        S_R: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 9'd1;
            // The beat counter, not RLAST, ends the burst; a disagreement only flags it
            if ((M_RRESP != 2'b00) || (M_RLAST != w_last)) begin
              r_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign RD_READY  = (r_state == S_IDLE) && r_idle_q;
  assign RD_ERR    = r_err;
  assign M_ARADDR  = r_araddr;
  assign M_ARLEN   = r_arlen;
  assign M_ARSIZE  = 3'b010;
  assign M_ARBURST = 2'b01;
  assign M_ARVALID = r_arvalid;
  assign M_RREADY  = w_rready;
  assign FIFO_WE   = w_beat;
  assign FIFO_DATA = M_RDATA;

endmodule
